// File: rtl/accum_scan_display_if.sv
// Board-side signal bundle for the accumulator: switch operand, op select, load button
// and the accumulator / seven-segment outputs.
interface accum_scan_display_if #(
    parameter int N = 8
);
    logic [N-1:0] x;
    logic [1:0]   op;
    logic         signed_mode;
    logic         btn;
    logic [N-1:0] acc;
    logic         ovf;
    logic [6:0]   sseg;
    logic [7:0]   AN;
    logic         DP;

    modport master (
        output x, op, signed_mode, btn,
        input  acc, ovf, sseg, AN, DP
    );

    modport slave (
        input  x, op, signed_mode, btn,
        output acc, ovf, sseg, AN, DP
    );
endinterface

// File: rtl/accum_scan_display.sv
// N-bit accumulator loaded by a debounced button press, with sticky overflow and a
// time-multiplexed hex seven-segment display of the accumulator.
module accum_scan_display #(
    parameter int N               = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REFRESH_BITS    = 17
) (
    input logic                clk,
    input logic                reset,
    accum_scan_display_if.slave bus
);
    localparam int DIGITS = N / 4;
    localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_CLR  = 2'b10,
        OP_HOLD = 2'b11
    } op_e;

    function automatic logic [6:0] hex_font(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // carry/borrow for the unsigned rule; sign-flip test for the two's-complement rule
    function automatic logic ovf_detect(
        input logic [N-1:0] a,
        input logic [N-1:0] b,
        input logic [N:0]   r,
        input logic         is_sub,
        input logic         sm
    );
        logic signed [N-1:0] sa;
        logic signed [N-1:0] sb;
        logic signed [N-1:0] sr;
        logic                ov;
        sa = a;
        sb = b;
        sr = r[N-1:0];
        if (!sm)
            ov = r[N];
        else if (is_sub)
            ov = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
        else
            ov = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
        return ov;
    endfunction

    logic                    sync1_q, sync1_d;
    logic                    sync2_q, sync2_d;
    logic                    stable_q, stable_d;
    logic                    stable_prev_q, stable_prev_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [N-1:0]            acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [2:0]              idx_q, idx_d;

    logic                    load;
    logic [N:0]              sum;
    logic [N:0]              diff;
    logic [3:0]              nibble;
    logic [7:0]              an_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
            acc_q         <= '0;
            ovf_q         <= 1'b0;
            refresh_q     <= '0;
            idx_q         <= 3'd0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            ovf_q         <= ovf_d;
            refresh_q     <= refresh_d;
            idx_q         <= idx_d;
        end
    end

    // Button synchronizer and debounce
    always_comb begin
        sync1_d       = bus.btn;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        cnt_d         = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST)
                stable_d = sync2_q;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    assign load = stable_q & ~stable_prev_q;

    // Accumulator update on the load cycle
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, bus.x};
        diff  = {1'b0, acc_q} - {1'b0, bus.x};
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (load) begin
            case (op_e'(bus.op))
                OP_ADD: begin
                    acc_d = sum[N-1:0];
                    ovf_d = ovf_q | ovf_detect(acc_q, bus.x, sum, 1'b0, bus.signed_mode);
                end
                OP_SUB: begin
                    acc_d = diff[N-1:0];
                    ovf_d = ovf_q | ovf_detect(acc_q, bus.x, diff, 1'b1, bus.signed_mode);
                end
                OP_CLR: begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Digit scan
    always_comb begin
        refresh_d = refresh_q + 1'b1;
        idx_d     = idx_q;
        if (&refresh_q)
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    end

    always_comb begin
        nibble = acc_q[3:0];
        an_w   = 8'hFF;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx_q == 3'(d)) begin
                nibble  = acc_q[4*d +: 4];
                an_w[d] = 1'b0;
            end
        end
    end

    assign bus.acc  = acc_q;
    assign bus.ovf  = ovf_q;
    assign bus.AN   = an_w;
    assign bus.sseg = hex_font(nibble);
    assign bus.DP   = ~(ovf_q && (idx_q == IDX_LAST));

endmodule

// File: tb/tb_accum_scan_display.sv
// Directed bench for accum_scan_display at N=8, DEBOUNCE_CYCLES=4, REFRESH_BITS=2.
module tb_accum_scan_display;
    int   n_cmp = 0;
    int   n_err = 0;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    accum_scan_display_if #(.N(8)) bus ();

    accum_scan_display #(
        .N(8),
        .DEBOUNCE_CYCLES(4),
        .REFRESH_BITS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [1:0] op, input logic [7:0] x, input logic sm);
        bus.op          = op;
        bus.x           = x;
        bus.signed_mode = sm;
        bus.btn         = 1'b1;
        tick(10);
        bus.btn = 1'b0;
        tick(10);
    endtask

    task automatic chk_acc(input string tag, input logic [7:0] a, input logic o);
        chk({tag, "_acc"}, 32'(bus.acc), 32'(a));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(o));
    endtask

    initial begin
        int k;
        logic [7:0] an_exp;
        logic [6:0] seg_exp;
        logic       dp_exp;

        bus.btn         = 1'b0;
        bus.x           = 8'h00;
        bus.op          = 2'b00;
        bus.signed_mode = 1'b0;

        // Reset held
        tick(10);
        chk_acc("rst", 8'h00, 1'b0);
        chk("rst_an", 32'(bus.AN), 32'hFE);
        chk("rst_sseg", 32'(bus.sseg), 32'(7'b1000000));
        chk("rst_dp", 32'(bus.DP), 32'h1);

        // Reset mid-debounce
        reset = 1'b0;
        tick(1);
        bus.op  = 2'b00;
        bus.x   = 8'h01;
        bus.btn = 1'b1;
        tick(3);
        #2 reset = 1'b1;
        bus.btn = 1'b0;
        #1;
        chk_acc("mid_rst", 8'h00, 1'b0);
        chk("mid_rst_an", 32'(bus.AN), 32'hFE);
        chk("mid_rst_sseg", 32'(bus.sseg), 32'(7'b1000000));
        @(posedge clk);
        #1 reset = 1'b0;
        tick(12);
        chk_acc("after_rst", 8'h00, 1'b0);

        // Short pulse and bounce produce no load
        bus.btn = 1'b1;
        tick(3);
        bus.btn = 1'b0;
        tick(8);
        chk_acc("short3", 8'h00, 1'b0);
        bus.btn = 1'b1; tick(1);
        bus.btn = 1'b0; tick(1);
        bus.btn = 1'b1; tick(1);
        bus.btn = 1'b0; tick(8);
        chk_acc("bounce", 8'h00, 1'b0);

        // Held button: exactly one load, at edge 7
        bus.op = 2'b00; bus.x = 8'h01; bus.signed_mode = 1'b0;
        bus.btn = 1'b1;
        tick(6);
        chk("pre_load_acc", 32'(bus.acc), 32'h00);
        tick(1);
        chk("edge7_acc", 32'(bus.acc), 32'h01);
        tick(43);
        chk("held_once_acc", 32'(bus.acc), 32'h01);
        bus.btn = 1'b0;
        tick(10);
        chk("release_acc", 32'(bus.acc), 32'h01);

        // Unsigned add with carry, then hold
        press(2'b10, 8'h00, 1'b0);
        chk_acc("clr0", 8'h00, 1'b0);
        press(2'b00, 8'hF0, 1'b0);
        chk_acc("uadd1", 8'hF0, 1'b0);
        press(2'b00, 8'hF0, 1'b0);
        chk_acc("uadd2", 8'hE0, 1'b1);
        press(2'b11, 8'h55, 1'b0);
        chk_acc("hold", 8'hE0, 1'b1);

        // Signed add/sub overflow and clear
        press(2'b10, 8'h00, 1'b0);
        press(2'b00, 8'h70, 1'b1);
        chk_acc("sadd70", 8'h70, 1'b0);
        press(2'b00, 8'h10, 1'b1);
        chk_acc("sadd10", 8'h80, 1'b1);
        press(2'b10, 8'h00, 1'b1);
        chk_acc("clr1", 8'h00, 1'b0);
        press(2'b00, 8'h80, 1'b0);
        chk_acc("uadd80", 8'h80, 1'b0);
        press(2'b01, 8'h01, 1'b1);
        chk_acc("ssub01", 8'h7F, 1'b1);

        // Unsigned borrow; inputs wiggled with no press
        press(2'b10, 8'h00, 1'b0);
        press(2'b01, 8'h01, 1'b0);
        chk_acc("usub01", 8'hFF, 1'b1);
        for (int i = 0; i < 12; i++) begin
            bus.op          = 2'(i);
            bus.x           = 8'(i * 17);
            bus.signed_mode = 1'(i);
            tick(1);
        end
        chk_acc("no_press", 8'hFF, 1'b1);

        // Display scan of 0xA5 with overflow set
        press(2'b10, 8'h00, 1'b0);
        press(2'b01, 8'h5B, 1'b0);
        chk_acc("usub5b", 8'hA5, 1'b1);
        k = 0;
        while (bus.AN !== 8'hFD && k < 20) begin tick(1); k++; end
        chk("sync_fd", 32'(bus.AN), 32'hFD);
        k = 0;
        while (bus.AN !== 8'hFE && k < 20) begin tick(1); k++; end
        chk("sync_fe", 32'(bus.AN), 32'hFE);
        for (int p = 0; p < 4; p++) begin
            an_exp  = (p % 2 == 0) ? 8'hFE : 8'hFD;
            seg_exp = (p % 2 == 0) ? 7'b0010010 : 7'b0001000;
            dp_exp  = (p % 2 == 0) ? 1'b1 : 1'b0;
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("scan_an_p%0d_c%0d", p, c), 32'(bus.AN), 32'(an_exp));
                chk($sformatf("scan_seg_p%0d_c%0d", p, c), 32'(bus.sseg), 32'(seg_exp));
                chk($sformatf("scan_dp_p%0d_c%0d", p, c), 32'(bus.DP), 32'(dp_exp));
                chk($sformatf("scan_hi_p%0d_c%0d", p, c), 32'(bus.AN[7:2]), 32'h3F);
                tick(1);
            end
        end

        // Reset mid-scan while digit 1 is lit
        tick(5);
        chk("pre_rst_an", 32'(bus.AN), 32'hFD);
        #2 reset = 1'b1;
        #1;
        chk_acc("scan_rst", 8'h00, 1'b0);
        chk("scan_rst_an", 32'(bus.AN), 32'hFE);
        chk("scan_rst_sseg", 32'(bus.sseg), 32'(7'b1000000));
        chk("scan_rst_dp", 32'(bus.DP), 32'h1);
        @(posedge clk);
        #1 reset = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/accum_scan_display.md
Name: accum_scan_display

Overview:
- Parametrised successor to the single-digit accumulator.
- N-bit register accumulates a switch operand on each debounced button press.
- Supports add, subtract, clear and hold ops, with a sticky signed/unsigned overflow flag.
- Drives a time-multiplexed multi-digit hex 7-segment display.
- Sits between the board switches/button and the 8-digit seven-segment display.

Parameters:
- N, 8: accumulator width; multiple of 4, range 4..32. Derived DIGITS = N/4 (max 8).
- DEBOUNCE_CYCLES, 1000000: consecutive cycles the synchronized button must differ from its stable value before the stable value changes; >= 1.
- REFRESH_BITS, 17: width of the free-running refresh counter. The digit advances each time it wraps.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- x  in  N  operand from switches.
- op  in  2  operation, sampled on the load cycle: 00 add, 01 sub, 10 clear, 11 hold.
- signed_mode  in  1  1 = two's-complement overflow rule; 0 = unsigned rule. Sampled on the load cycle.
- btn  in  1  raw, asynchronous, bouncy load button.
- acc  out  N  accumulator value.
- ovf  out  1  sticky overflow flag.
- sseg  out  7  active-low segments {g,f,e,d,c,b,a}.
- AN  out  8  active-low digit enables.
- DP  out  1  active-low decimal point.

Behaviour:
- Reset (async, any time, including mid-debounce or mid-scan):
  - acc=0, ovf=0; synchronizer, stable and debounce counter cleared; refresh counter=0, digit index=0.
  - Outputs: AN=8'b11111110, sseg=7'b1000000 ("0"), DP=1.
- Synchronizer: 2-flop chain on btn.
- Debounce:
  - When sync != stable, the counter increments each cycle.
  - When the counter == DEBOUNCE_CYCLES-1 and sync still != stable: stable <= sync, counter <= 0.
  - Any cycle with sync == stable resets the counter to 0.
- Load pulse:
  - load = stable & ~stable_d (one cycle wide), on the rising edge of stable only.
  - A held button produces exactly one load. Release produces none.
- Latency: btn clean-high first sampled at edge 1 -> stable rises at edge 2+DEBOUNCE_CYCLES -> acc/ovf update at edge 3+DEBOUNCE_CYCLES.
- On load:
  - add: acc <= (acc+x) mod 2^N.
  - sub: acc <= (acc-x) mod 2^N.
  - clear: acc <= 0, ovf <= 0.
  - hold: no change.
- Overflow (add/sub only; ovf is set and stays set until clear or reset):
  - unsigned: carry-out on add, borrow (x > acc) on sub.
  - signed: operands of equal sign yielding a result of different sign on add; operands of different sign yielding a result whose sign differs from acc on sub.
- Changes to op, x or signed_mode outside the load cycle have no effect.
- Scan:
  - Refresh counter increments every cycle.
  - When it wraps from all-ones to 0, the digit index increments modulo DIGITS.
  - AN[idx]=0, all other AN bits=1; anodes >= DIGITS are always 1.
  - sseg = hex font of acc[4*idx+3:4*idx]. Font (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- DP = 0 only when ovf=1 and idx == DIGITS-1; otherwise 1.
- Display is combinational from acc and idx: a new acc is visible in the same cycle it is registered.

Test Plan (N=8, DEBOUNCE_CYCLES=4, REFRESH_BITS=2):
- Reset, then hold 10 cycles -> acc=0x00, ovf=0, AN=FE, sseg=1000000, DP=1. Assert reset mid-debounce -> same values, no load afterward.
- btn high 3 cycles then low; then btn bouncing 1,0,1,0 -> acc unchanged. btn held high 50 cycles -> exactly one load, at edge 7 after first high sample.
- Unsigned, op=add, x=0xF0, two presses -> acc=0xF0 with ovf=0, then acc=0xE0 with ovf=1. op=hold press -> acc=0xE0, ovf=1.
- Signed, acc=0x70, add x=0x10 -> acc=0x80, ovf=1. op=clear press -> acc=0x00, ovf=0. Signed sub x=0x01 from 0x80 -> acc=0x7F, ovf=1.
- Unsigned sub x=0x01 from 0x00 -> acc=0xFF, ovf=1. Change op/x while btn stable -> no update.
- acc=0xA5, ovf=1 -> AN alternates FE/FD every 4 cycles. Digit0: sseg=0010010, DP=1. Digit1: sseg=0001000, DP=0. AN[7:2] always 1.
